// File: rtl/xbus_mcast_ctrl.sv
// Row-bus (X-bus) multicast controller: filters tagged packets by row ID and delivers them to
// every column PE whose ID matches the column tag. Optional drop counter: XBUS_DROP_CNT_EN.
module xbus_mcast_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_COL    = 4,
  parameter int unsigned NUM_ROW    = 4,
  parameter int unsigned NUM_TAG    = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned RW = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1,
  localparam int unsigned CW = (NUM_TAG > 1) ? $clog2(NUM_TAG) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cfg_en_i,
  input  logic [RW-1:0]           cfg_row_id_i,
  input  logic [NUM_COL*CW-1:0]   cfg_col_id_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [RW-1:0]           in_row_tag_i,
  input  logic [CW-1:0]           in_col_tag_i,
  input  logic [DATA_WIDTH-1:0]   in_data_i,
  output logic [NUM_COL-1:0]      out_valid_o,
  input  logic [NUM_COL-1:0]      out_ready_i,
  output logic [DATA_WIDTH-1:0]   out_data_o,
  output logic                    busy_o
`ifdef XBUS_DROP_CNT_EN
  ,
  output logic [15:0]             drop_cnt_o
`endif
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned EW = NUM_COL + DATA_WIDTH;
  localparam logic [PW:0] FullCnt = FIFO_DEPTH[PW:0];

  typedef enum logic [0:0] {StUncfg, StRun} state_e;

  state_e                  state_q;
  logic [RW-1:0]           row_id_q;
  logic [NUM_COL*CW-1:0]   col_id_q;
  logic [EW-1:0]           mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wptr_q, rptr_q;
  logic [PW:0]             count_q;
  logic [NUM_COL-1:0]      pending_q;
  logic [DATA_WIDTH-1:0]   data_q;

  logic [NUM_COL-1:0]      col_match;
  logic [NUM_COL-1:0]      pending_nxt;
  logic                    fifo_full, fifo_empty;
  logic                    accept, push, pop, stage_free;

  always_comb begin
    col_match = '0;
    for (int c = 0; c < NUM_COL; c++) begin
      col_match[c] = (col_id_q[c*CW +: CW] == in_col_tag_i);
    end
  end

  assign fifo_full   = (count_q == FullCnt);
  assign fifo_empty  = (count_q == '0);
  assign in_ready_o  = (state_q == StRun) & ~fifo_full & ~cfg_en_i;
  assign accept      = in_valid_i & in_ready_o;
  // Packets for another row or with no matching column are consumed without a FIFO write.
  assign push        = accept & (in_row_tag_i == row_id_q) & (|col_match);

  // Stage frees up in the same cycle its last target handshakes, allowing 1 packet/cycle.
  assign pending_nxt = pending_q & ~out_ready_i;
  assign stage_free  = ~|pending_nxt;
  assign pop         = stage_free & ~fifo_empty;

  assign out_valid_o = pending_q;
  assign out_data_o  = (|pending_q) ? data_q : '0;
  assign busy_o      = ~fifo_empty | (|pending_q);

  // Storage only; a flush just resets the pointers, so the contents need no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= {col_match, in_data_i};
    end
  end

`ifdef XBUS_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  logic        drop;

  assign drop       = accept & ~push;
  assign drop_cnt_o = drop_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
    end else if (cfg_en_i) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StUncfg;
      row_id_q  <= '0;
      col_id_q  <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      pending_q <= '0;
      data_q    <= '0;
    end else begin
      unique case (state_q)
        StUncfg: begin
          if (cfg_en_i) begin
            state_q  <= StRun;
            row_id_q <= cfg_row_id_i;
            col_id_q <= cfg_col_id_i;
          end
        end
        StRun: begin
          if (cfg_en_i) begin
            // Reconfigure and discard everything in flight without handshakes.
            row_id_q  <= cfg_row_id_i;
            col_id_q  <= cfg_col_id_i;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            pending_q <= '0;
            data_q    <= '0;
          end else begin
            if (push) begin
              wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
              rptr_q    <= rptr_q + 1'b1;
              pending_q <= mem_q[rptr_q][EW-1:DATA_WIDTH];
              data_q    <= mem_q[rptr_q][DATA_WIDTH-1:0];
            end else begin
              pending_q <= pending_nxt;
            end
            unique case ({push, pop})
              2'b10:   count_q <= count_q + 1'b1;
              2'b01:   count_q <= count_q - 1'b1;
              default: count_q <= count_q;
            endcase
          end
        end
        default: state_q <= StUncfg;
      endcase
    end
  end

endmodule

// File: tb/tb_xbus_mcast_ctrl.sv
// Scoreboard bench for xbus_mcast_ctrl (default 4x4 config, FIFO_DEPTH=4).
module tb_xbus_mcast_ctrl;

  localparam logic [7:0] ColCfg = {2'd3, 2'd1, 2'd1, 2'd0};

  typedef struct packed {
    logic [3:0]  mask;
    logic [15:0] data;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_en;
  logic [1:0]  cfg_row_id;
  logic [7:0]  cfg_col_id;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_row_tag;
  logic [1:0]  in_col_tag;
  logic [15:0] in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data;
  logic        busy;
`ifdef XBUS_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  pkt_t exp_q[$];
  pkt_t e;

  always #5 clk = ~clk;

  xbus_mcast_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cfg_en_i     (cfg_en),
    .cfg_row_id_i (cfg_row_id),
    .cfg_col_id_i (cfg_col_id),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_row_tag_i (in_row_tag),
    .in_col_tag_i (in_col_tag),
    .in_data_i    (in_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .busy_o       (busy)
`ifdef XBUS_DROP_CNT_EN
    ,
    .drop_cnt_o   (drop_cnt)
`endif
  );

  function automatic logic [3:0] exp_mask(input logic [1:0] tag);
    logic [7:0] cfg;
    logic [3:0] m;
    cfg = ColCfg;
    m   = '0;
    for (int c = 0; c < 4; c++) m[c] = (cfg[c*2 +: 2] == tag);
    return m;
  endfunction

  function automatic pkt_t pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic drive_pkt(input logic [1:0] row, input logic [1:0] col, input logic [15:0] d);
    in_valid   = 1'b1;
    in_row_tag = row;
    in_col_tag = col;
    in_data    = d;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_cmp++;
    if ({in_ready, out_valid, out_data, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b v=%b d=%h busy=%b, want all 0",
               in_ready, out_valid, out_data, busy);
    end
    rst_n = 1'b1;
    drive_pkt(2'd2, 2'd1, 16'h5555);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 4'b0) begin
        n_bad++;
        $display("FAIL uncfg_idle: got rdy=%b v=%b, want 0/0000", in_ready, out_valid);
      end
    end
    @(negedge clk);
    in_valid   = 1'b0;
    cfg_en     = 1'b1;
    cfg_row_id = 2'd2;
    cfg_col_id = ColCfg;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_during_cfg: got %b, want 0", in_ready);
    end
    @(negedge clk);
    cfg_en = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_cfg: got %b, want 1", in_ready);
    end
  endtask

  task automatic test_single();
    out_ready = 4'hF;
    @(negedge clk);
    drive_pkt(2'd2, 2'd1, 16'h00AB);
    exp_q.push_back('{mask: exp_mask(2'd1), data: 16'h00AB});
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 4'b0) begin
      n_bad++;
      $display("FAIL single_latency: got v=%b at N+1, want 0000", out_valid);
    end
    @(negedge clk);
    e = pop_exp();
    n_cmp++;
    if ({out_valid, out_data} !== e) begin
      n_bad++;
      $display("FAIL single_deliver: got v=%b d=%h, want v=%b d=%h",
               out_valid, out_data, e.mask, e.data);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 4'b0 || out_data !== 16'h0) begin
      n_bad++;
      $display("FAIL single_one_cycle: got v=%b d=%h, want 0000/0000", out_valid, out_data);
    end
  endtask

  task automatic test_partial_ready();
    out_ready = 4'b0010;
    @(negedge clk);
    drive_pkt(2'd2, 2'd1, 16'h00AB);
    exp_q.push_back('{mask: exp_mask(2'd1), data: 16'h00AB});
    @(negedge clk);
    drive_pkt(2'd2, 2'd1, 16'h00CD);
    exp_q.push_back('{mask: exp_mask(2'd1), data: 16'h00CD});
    @(negedge clk);
    in_valid = 1'b0;
    e = pop_exp();
    n_cmp++;
    if ({out_valid, out_data} !== e) begin
      n_bad++;
      $display("FAIL partial_first: got v=%b d=%h, want v=%b d=%h",
               out_valid, out_data, e.mask, e.data);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 4'b0100 || out_data !== 16'h00AB) begin
      n_bad++;
      $display("FAIL partial_hold: got v=%b d=%h, want 0100/00ab", out_valid, out_data);
    end
    out_ready = 4'b0100;
    @(negedge clk);
    e = pop_exp();
    n_cmp++;
    if ({out_valid, out_data} !== e) begin
      n_bad++;
      $display("FAIL partial_next: got v=%b d=%h, want v=%b d=%h",
               out_valid, out_data, e.mask, e.data);
    end
    out_ready = 4'hF;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 4'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL partial_drain: got v=%b busy=%b, want 0000/0", out_valid, busy);
    end
  endtask

  task automatic test_drop();
    out_ready = 4'hF;
    @(negedge clk);
    drive_pkt(2'd1, 2'd1, 16'h0011);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_row_accept: got rdy=%b, want 1", in_ready);
    end
    @(negedge clk);
    drive_pkt(2'd2, 2'd2, 16'h0022);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_col_accept: got rdy=%b, want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 4'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL drop_silent: got v=%b busy=%b, want 0000/0", out_valid, busy);
      end
    end
`ifdef XBUS_DROP_CNT_EN
    n_cmp++;
    if (drop_cnt !== 16'd2) begin
      n_bad++;
      $display("FAIL drop_cnt: got %0d, want 2", drop_cnt);
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [1:0] tag;
    out_ready = 4'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tag = (i % 2 == 1) ? 2'd3 : 2'd1;
      drive_pkt(2'd2, tag, 16'h0100 + 16'(i));
      if (i < 5) exp_q.push_back('{mask: exp_mask(tag), data: 16'h0100 + 16'(i)});
      #1;
      n_cmp++;
      if (in_ready !== (i < 5)) begin
        n_bad++;
        $display("FAIL bp_ready[%0d]: got %b, want %b", i, in_ready, (i < 5));
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 4'hF;
    for (int j = 0; j < 5; j++) begin
      #1;
      e = pop_exp();
      n_cmp++;
      if ({out_valid, out_data} !== e) begin
        n_bad++;
        $display("FAIL bp_deliver[%0d]: got v=%b d=%h, want v=%b d=%h",
                 j, out_valid, out_data, e.mask, e.data);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (out_valid !== 4'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_drain: got v=%b busy=%b, want 0000/0", out_valid, busy);
    end
  endtask

  task automatic test_flush();
    out_ready = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_pkt(2'd2, 2'd0, 16'h0200 + 16'(i));
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 4'b0001 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_pre: got v=%b busy=%b, want 0001/1", out_valid, busy);
    end
    cfg_en = 1'b1;
    @(negedge clk);
    cfg_en = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 4'b0 || busy !== 1'b0 || out_data !== 16'h0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_post: got v=%b busy=%b d=%h rdy=%b, want 0000/0/0000/1",
               out_valid, busy, out_data, in_ready);
    end
    out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 4'b0) begin
        n_bad++;
        $display("FAIL flush_no_ghost[%0d]: got v=%b, want 0000", i, out_valid);
      end
    end
`ifdef XBUS_DROP_CNT_EN
    n_cmp++;
    if (drop_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL flush_drop_cnt: got %0d, want 0", drop_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [1:0] tags [4];
    tags = '{2'd1, 2'd3, 2'd0, 2'd1};
    out_ready = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = pop_exp();
        n_cmp++;
        if ({out_valid, out_data} !== e) begin
          n_bad++;
          $display("FAIL b2b[%0d]: got v=%b d=%h, want v=%b d=%h",
                   i - 2, out_valid, out_data, e.mask, e.data);
        end
      end
      if (i < 4) begin
        drive_pkt(2'd2, tags[i], 16'h0300 + 16'(i));
        exp_q.push_back('{mask: exp_mask(tags[i]), data: 16'h0300 + 16'(i)});
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 4'b0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_end: got v=%b left=%0d, want 0000/0", out_valid, exp_q.size());
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    cfg_en     = 1'b0;
    cfg_row_id = '0;
    cfg_col_id = '0;
    in_valid   = 1'b0;
    in_row_tag = '0;
    in_col_tag = '0;
    in_data    = '0;
    out_ready  = '0;
    test_reset();
    test_single();
    test_partial_ready();
    test_drop();
    test_backpressure();
    test_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xbus_mcast_ctrl.md
Name: xbus_mcast_ctrl

Overview:
Parametrised row-bus (X-bus) controller for the PE array; one instance per row. Accepts tagged packets from the global buffer with valid/ready and filters them by row tag. It multicasts each surviving packet to every column PE whose configured column ID matches the packet's column tag. A small FIFO decouples the global buffer from PE back-pressure; a packet retires only when every targeted PE has accepted it.

Parameters:
DATA_WIDTH, 16, payload width (ifmap/filter word; psum callers use 2*DATA_WIDTH instances)
NUM_COL, 4, PEs on this row bus
NUM_ROW, 4, rows in array; RW = max(1,$clog2(NUM_ROW))
NUM_TAG, 4, column tag space; CW = max(1,$clog2(NUM_TAG))
FIFO_DEPTH, 4, input FIFO entries, power of two, >= 2

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
cfg_en  in  1  load config + flush (one-cycle pulse)
cfg_row_id  in  RW  this row's ID
cfg_col_id  in  NUM_COL*CW  column ID of PE c in bits [c*CW +: CW]
in_valid  in  1  packet valid from global buffer
in_ready  out  1  controller can accept packet
in_row_tag  in  RW  destination row tag
in_col_tag  in  CW  destination column tag
in_data  in  DATA_WIDTH  payload
out_valid  out  NUM_COL  per-PE valid
out_ready  in  NUM_COL  per-PE ready
out_data  out  DATA_WIDTH  payload shared by all PEs
busy  out  1  FIFO non-empty or delivery stage occupied

Behaviour:
- Reset: state UNCFG, FIFO empty, delivery stage empty, row/col ID registers 0; in_ready=0, out_valid=0, out_data=0, busy=0.
- FSM UNCFG -> RUN on cfg_en. In RUN, cfg_en reloads IDs, empties FIFO and delivery stage, and stays in RUN. Any in-flight or queued packet is discarded without handshake. Flush takes effect at the clock edge; next cycle busy=0.
- in_ready = (state==RUN) & !fifo_full & !cfg_en.
- Accept when in_valid & in_ready. At accept: mask[c] = (cfg_col_id[c]==in_col_tag). If in_row_tag != row ID or mask==0, the packet is consumed and dropped; FIFO is not written. Otherwise {mask,in_data} is written to the FIFO.
- Delivery stage register holds {pending[NUM_COL], data}. out_valid = pending; out_data = data (0 when stage empty).
- pending[c] clears on out_valid[c] & out_ready[c]. PEs may accept in different cycles; out_data is held stable until all bits have cleared.
- Stage is free when pending==0, or will be 0 after this cycle's handshakes. When free and FIFO non-empty, pop the head into the stage in the same cycle, giving a sustained 1 packet/cycle when all targets are ready.
- Latency: accept in cycle N with FIFO empty and stage free -> out_valid in cycle N+2.
- FIFO full: in_ready=0 even for packets that would be dropped. Simultaneous push and pop while full is not allowed, because in_ready is already low. Push and pop in the same cycle at other occupancies keeps the count unchanged.
- Pointers wrap modulo FIFO_DEPTH; occupancy counter is 0..FIFO_DEPTH.
- out_ready on a column with out_valid=0 is ignored.
- busy = (count!=0) | (pending!=0).

Optional Feature:
XBUS_DROP_CNT_EN: when defined, adds output drop_cnt[15:0]. It increments on each dropped accepted packet (row mismatch or empty mask), saturates at 16'hFFFF, clears on reset and cfg_en. When undefined, the port and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, no cfg_en, in_valid=1 -> in_ready=0, out_valid=0 indefinitely; cfg_en row_id=2 -> in_ready=1 next cycle.
- Row 2, col IDs {0,1,1,3}; send row_tag=2, col_tag=1, data=0x00AB with all ready -> out_valid=4'b0110 two cycles later, out_data=0x00AB for one cycle.
- Same packet, out_ready=4'b0010 first cycle then 4'b0100 -> out_valid 0110, 0100, 0000; out_data stable throughout; next packet not presented until pending is empty.
- row_tag=1, then col_tag=2 (no match) -> both accepted, no out_valid; with XBUS_DROP_CNT_EN drop_cnt=2.
- out_ready=0, stream 6 matching packets with FIFO_DEPTH=4 -> 5 accepted (4 FIFO + 1 stage), in_ready low; release ready -> 5 packets delivered in order, one per cycle.
- cfg_en with 3 queued packets and pending=4'b0001 -> next cycle out_valid=0, busy=0, no queued data ever delivered.
